// File: rtl/rps_match_controller_if.sv
// Bus between the rock-paper-scissors controller and the player input,
// choice counter and display logic. The master side drives the throws and
// start requests; the slave side is the controller.
interface rps_match_controller_if #(
   parameter int SCORE_W = 3
);
   logic               start;
   logic               player_valid;
   logic [1:0]         player;
   logic [1:0]         computer;
   logic               counter_run;
   logic [1:0]         result;
   logic               result_valid;
   logic [SCORE_W-1:0] player_score;
   logic [SCORE_W-1:0] cpu_score;
   logic [7:0]         round_count;
   logic               match_over;
   logic               match_winner;

   modport master (
      output start, player_valid, player, computer,
      input  counter_run, result, result_valid, player_score, cpu_score,
             round_count, match_over, match_winner
   );

   modport slave (
      input  start, player_valid, player, computer,
      output counter_run, result, result_valid, player_score, cpu_score,
             round_count, match_over, match_winner
   );
endinterface

// File: rtl/rps_match_controller.sv
// First-to-WIN_TARGET match sequencer: runs and freezes the choice counter,
// captures the player's throw, judges the round, keeps scores and holds each
// result for REVEAL_CYCLES before the next round.
//
// state  | meaning
// IDLE   | waiting for start, counter frozen
// SPIN   | counter running, waiting for a valid player throw
// EVAL   | one cycle, judging the latched throw pair
// REVEAL | result displayed for REVEAL_CYCLES, counter frozen
// DONE   | match decided, results held until start
module rps_match_controller #(
   parameter int WIN_TARGET    = 3,
   parameter int REVEAL_CYCLES = 4,
   parameter int SCORE_W       = 3
) (
   input logic                  clk,
   input logic                  clear,
   rps_match_controller_if.slave bus
);

   localparam int CNT_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]   REVEAL_LOAD = CNT_W'(REVEAL_CYCLES - 1);
   localparam logic [SCORE_W-1:0] WIN_TGT     = SCORE_W'(WIN_TARGET);

   typedef enum logic [2:0] {IDLE, SPIN, EVAL, REVEAL, DONE} state_t;

   state_t             state, state_nxt;
   logic [1:0]         player_lat, computer_lat;
   logic [1:0]         outcome;
   logic [CNT_W-1:0]   reveal_cnt;
   logic [1:0]         result_r;
   logic               result_valid_r;
   logic [SCORE_W-1:0] player_score_r, cpu_score_r;
   logic [7:0]         round_count_r;
   logic               match_winner_r;
   logic               accept;
   logic               counter_run_d, match_over_d;

   assign accept = bus.player_valid && (bus.player != 2'b11);

   // State register; clear wins over everything.
   always_ff @(posedge clk) begin
      if (clear) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SPIN;
         SPIN:    if (accept) state_nxt = EVAL;
         EVAL:    state_nxt = REVEAL;
         REVEAL:  if (reveal_cnt == '0) begin
                     if (player_score_r == WIN_TGT || cpu_score_r == WIN_TGT) state_nxt = DONE;
                     else state_nxt = SPIN;
                  end
         DONE:    if (bus.start) state_nxt = SPIN;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs decoded from state.
   always_comb begin
      counter_run_d = 1'b0;
      match_over_d  = 1'b0;
      case (state)
         SPIN:    counter_run_d = 1'b1;
         DONE:    match_over_d  = 1'b1;
         default: ;
      endcase
   end

   // Round judgement on the latched pair: equal is a draw, otherwise the
   // player wins only on the three beating pairs.
   always_comb begin
      outcome = 2'b01;
      if (player_lat == computer_lat) outcome = 2'b11;
      else if ((player_lat == 2'b00 && computer_lat == 2'b10) ||
               (player_lat == 2'b01 && computer_lat == 2'b00) ||
               (player_lat == 2'b10 && computer_lat == 2'b01)) outcome = 2'b00;
   end

   // Throw capture, scoring, reveal timer and winner latch.
   always_ff @(posedge clk) begin
      if (clear) begin
         player_lat     <= 2'b00;
         computer_lat   <= 2'b00;
         reveal_cnt     <= '0;
         result_r       <= 2'b11;
         result_valid_r <= 1'b0;
         player_score_r <= '0;
         cpu_score_r    <= '0;
         round_count_r  <= 8'd0;
         match_winner_r <= 1'b0;
      end else begin
         result_valid_r <= 1'b0;
         case (state)
            IDLE, DONE: if (bus.start) begin
               player_score_r <= '0;
               cpu_score_r    <= '0;
               round_count_r  <= 8'd0;
            end
            SPIN: if (accept) begin
               player_lat   <= bus.player;
               computer_lat <= bus.computer;
            end
            EVAL: begin
               result_r       <= outcome;
               result_valid_r <= 1'b1;
               round_count_r  <= round_count_r + 8'd1;
               reveal_cnt     <= REVEAL_LOAD;
               if (outcome == 2'b00) player_score_r <= player_score_r + 1'b1;
               if (outcome == 2'b01) cpu_score_r    <= cpu_score_r + 1'b1;
            end
            REVEAL: begin
               if (reveal_cnt != '0) reveal_cnt <= reveal_cnt - 1'b1;
               else if (player_score_r == WIN_TGT) match_winner_r <= 1'b0;
               else if (cpu_score_r == WIN_TGT) match_winner_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.counter_run  = counter_run_d;
   assign bus.match_over   = match_over_d;
   assign bus.result       = result_r;
   assign bus.result_valid = result_valid_r;
   assign bus.player_score = player_score_r;
   assign bus.cpu_score    = cpu_score_r;
   assign bus.round_count  = round_count_r;
   assign bus.match_winner = match_winner_r;

endmodule

// File: tb/tb_rps_match_controller.sv
// Bench for rps_match_controller: two instances (default parameters and a
// long-match variant) share one stimulus stream; each is compared every
// cycle against an event-time model of the match rules.
module tb_rps_match_controller;

   logic       clk = 1'b0;
   logic       clear, start, pv;
   logic [1:0] player, computer;
   bit         chk_en = 1'b0;
   int         n_pass = 0, n_total = 0;
   int         t = 0;

   always #5 clk = ~clk;

   rps_match_controller_if #(.SCORE_W(3)) bus_a ();
   rps_match_controller_if #(.SCORE_W(3)) bus_b ();

   assign bus_a.start = start;  assign bus_a.player_valid = pv;
   assign bus_a.player = player; assign bus_a.computer = computer;
   assign bus_b.start = start;  assign bus_b.player_valid = pv;
   assign bus_b.player = player; assign bus_b.computer = computer;

   rps_match_controller #(.WIN_TARGET(3), .REVEAL_CYCLES(4), .SCORE_W(3)) dut_a (
      .clk(clk), .clear(clear), .bus(bus_a));
   rps_match_controller #(.WIN_TARGET(7), .REVEAL_CYCLES(2), .SCORE_W(3)) dut_b (
      .clk(clk), .clear(clear), .bus(bus_b));

   // Match model: tracks whether the counter spins, when a throw was
   // accepted, and derives judge/reveal-end events from that timestamp.
   typedef struct {
      bit         spinning, over, pend, rv, win;
      int         acc, ps, cs, rounds;
      logic [1:0] lp, lc, res;
   } model_t;

   model_t ma, mb;

   function automatic model_t model_reset();
      model_t m;
      m.spinning = 0; m.over = 0; m.pend = 0; m.rv = 0; m.win = 0;
      m.acc = 0; m.ps = 0; m.cs = 0; m.rounds = 0;
      m.lp = 0; m.lc = 0; m.res = 2'b11;
      return m;
   endfunction

   function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] c);
      if (p == c) return 2'b11;
      if (c == 2'b11) return 2'b01;
      if (((int'(p) - int'(c) + 3) % 3) == 1) return 2'b00;
      return 2'b01;
   endfunction

   function automatic model_t step(input model_t m, input int tt, input logic clr,
                                   input logic st, input logic v, input logic [1:0] p,
                                   input logic [1:0] c, input int wt, input int rc);
      model_t n = m;
      n.rv = 0;
      if (clr) return model_reset();
      if (m.pend) begin
         if (tt == m.acc + 1) begin
            n.res = judge(m.lp, m.lc);
            if (n.res == 2'b00) n.ps++;
            if (n.res == 2'b01) n.cs++;
            n.rounds = (m.rounds + 1) % 256;
            n.rv = 1;
         end
         if (tt == m.acc + 1 + rc) begin
            n.pend = 0;
            if (n.ps == wt) begin n.over = 1; n.win = 0; end
            else if (n.cs == wt) begin n.over = 1; n.win = 1; end
            else n.spinning = 1;
         end
      end else if (m.spinning) begin
         if (v && p != 2'b11) begin
            n.spinning = 0; n.pend = 1; n.acc = tt; n.lp = p; n.lc = c;
         end
      end else if (st) begin
         n.spinning = 1; n.over = 0; n.ps = 0; n.cs = 0; n.rounds = 0;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      ma = step(ma, t, clear, start, pv, player, computer, 3, 4);
      mb = step(mb, t, clear, start, pv, player, computer, 7, 2);
      t++;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at time %0t", nm, got, exp, $time);
   endtask

   task automatic cmp(input string nm, input model_t m, input logic [31:0] cr,
                      input logic [31:0] res, input logic [31:0] rv, input logic [31:0] ps,
                      input logic [31:0] cs, input logic [31:0] rc, input logic [31:0] mo,
                      input logic [31:0] mw);
      chk({nm, ".counter_run"},  cr, 32'(m.spinning));
      chk({nm, ".result"},       res, 32'(m.res));
      chk({nm, ".result_valid"}, rv, 32'(m.rv));
      chk({nm, ".player_score"}, ps, 32'(m.ps));
      chk({nm, ".cpu_score"},    cs, 32'(m.cs));
      chk({nm, ".round_count"},  rc, 32'(m.rounds));
      chk({nm, ".match_over"},   mo, 32'(m.over));
      chk({nm, ".match_winner"}, mw, 32'(m.win));
   endtask

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("a", ma, 32'(bus_a.counter_run), 32'(bus_a.result), 32'(bus_a.result_valid),
             32'(bus_a.player_score), 32'(bus_a.cpu_score), 32'(bus_a.round_count),
             32'(bus_a.match_over), 32'(bus_a.match_winner));
         cmp("b", mb, 32'(bus_b.counter_run), 32'(bus_b.result), 32'(bus_b.result_valid),
             32'(bus_b.player_score), 32'(bus_b.cpu_score), 32'(bus_b.round_count),
             32'(bus_b.match_over), 32'(bus_b.match_winner));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Present a throw for one edge; returns at the negedge after the accept edge.
   task automatic throw(input logic [1:0] p, input logic [1:0] c);
      player = p; computer = c; pv = 1'b1;
      tick();
      pv = 1'b0; computer = 2'($urandom_range(0, 2));
   endtask

   task automatic wait_spin_a(input int budget);
      bit seen = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         if (bus_a.counter_run === 1'b1) seen = 1;
         else tick();
      end
      if (!seen) chk("wait_spin_timeout", 32'(bus_a.counter_run), 32'd1);
   endtask

   // One round on instance a with literal expectations at j+1, j+2, j+5, j+6.
   task automatic do_round(input logic [1:0] p, input logic [1:0] c, input logic [1:0] eres,
                           input int eps, input int ecs, input int erc, input bit espin);
      throw(p, c);
      chk("lit.frozen_j1", 32'(bus_a.counter_run), 32'd0);
      tick();
      chk("lit.rv_j2",  32'(bus_a.result_valid), 32'd1);
      chk("lit.res_j2", 32'(bus_a.result), 32'(eres));
      chk("lit.ps_j2",  32'(bus_a.player_score), 32'(eps));
      chk("lit.cs_j2",  32'(bus_a.cpu_score), 32'(ecs));
      chk("lit.rc_j2",  32'(bus_a.round_count), 32'(erc));
      tick();
      chk("lit.rv_j3", 32'(bus_a.result_valid), 32'd0);
      repeat (2) tick();
      chk("lit.frozen_j5", 32'(bus_a.counter_run), 32'd0);
      tick();
      chk("lit.spin_j6", 32'(bus_a.counter_run), 32'(espin));
      chk("lit.over_j6", 32'(bus_a.match_over), 32'(!espin));
   endtask

   initial begin
      ma = model_reset(); mb = model_reset();
      clear = 1'b1; start = 1'b0; pv = 1'b0; player = 2'b00; computer = 2'b00;
      repeat (2) tick();
      clear = 1'b0; chk_en = 1'b1;

      repeat (4) begin
         tick();
         chk("lit.idle_run", 32'(bus_a.counter_run), 32'd0);
         chk("lit.idle_res", 32'(bus_a.result), 32'd3);
         chk("lit.idle_rc",  32'(bus_a.round_count), 32'd0);
      end

      start = 1'b1; tick(); start = 1'b0;
      chk("lit.start_run", 32'(bus_a.counter_run), 32'd1);

      player = 2'b11; pv = 1'b1; tick(); pv = 1'b0;
      chk("lit.invalid_run", 32'(bus_a.counter_run), 32'd1);
      tick();
      chk("lit.invalid_run2", 32'(bus_a.counter_run), 32'd1);

      do_round(2'b10, 2'b10, 2'b11, 0, 0, 1, 1'b1);
      do_round(2'b01, 2'b00, 2'b00, 1, 0, 2, 1'b1);
      do_round(2'b01, 2'b10, 2'b01, 1, 1, 3, 1'b1);
      do_round(2'b01, 2'b10, 2'b01, 1, 2, 4, 1'b1);
      do_round(2'b01, 2'b10, 2'b01, 1, 3, 5, 1'b0);
      chk("lit.winner_cpu", 32'(bus_a.match_winner), 32'd1);

      throw(2'b00, 2'b10); tick();
      chk("lit.done_hold_rc", 32'(bus_a.round_count), 32'd5);
      chk("lit.done_hold_mo", 32'(bus_a.match_over), 32'd1);
      start = 1'b1; tick(); start = 1'b0;
      chk("lit.restart_run", 32'(bus_a.counter_run), 32'd1);
      chk("lit.restart_cs",  32'(bus_a.cpu_score), 32'd0);
      chk("lit.restart_mo",  32'(bus_a.match_over), 32'd0);

      throw(2'b00, 2'b10);
      clear = 1'b1; tick(); clear = 1'b0;
      chk("lit.clr_eval_rv", 32'(bus_a.result_valid), 32'd0);
      chk("lit.clr_eval_rc", 32'(bus_a.round_count), 32'd0);
      chk("lit.clr_eval_res", 32'(bus_a.result), 32'd3);

      start = 1'b1; tick(); start = 1'b0;
      throw(2'b00, 2'b10); tick();
      clear = 1'b1; tick(); clear = 1'b0;
      chk("lit.clr_rev_rv",  32'(bus_a.result_valid), 32'd0);
      chk("lit.clr_rev_ps",  32'(bus_a.player_score), 32'd0);
      chk("lit.clr_rev_run", 32'(bus_a.counter_run), 32'd0);

      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         logic [1:0] c;
         c = 2'($urandom_range(0, 2));
         throw(c, c); tick();
         if (i == 254) chk("lit.rc_255", 32'(bus_a.round_count), 32'd255);
         if (i == 255) chk("lit.rc_wrap", 32'(bus_a.round_count), 32'd0);
         tick(); start = 1'b1; tick(); start = 1'b0;
         wait_spin_a(20);
      end
      chk("lit.rc_wrap_b", 32'(bus_b.round_count), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         clear    = ($urandom_range(0, 199) == 0);
         start    = ($urandom_range(0, 7) == 0);
         pv       = ($urandom_range(0, 2) == 0);
         player   = 2'($urandom_range(0, 3));
         computer = 2'($urandom_range(0, 3));
         tick();
      end
      clear = 1'b0; start = 1'b0; pv = 1'b0;
      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rps_match_controller.md
# rps_match_controller

Sequencing controller for the rock-paper-scissors arcade datapath. It runs a first-to-N match: it starts and freezes the free-running computer-choice counter, captures the player's throw, and judges each round. It also keeps both scores, holds each result for a fixed display window, and declares the match winner. It sits between the player input/button logic and the choice counter plus display drivers, and replaces ad-hoc `stop` handling at top level.

## Interface
Parameters:
- `WIN_TARGET`, default 3: round wins needed to take the match; legal range 1..(2^SCORE_W − 1).
- `REVEAL_CYCLES`, default 4: cycles each round result is held before the next round; legal range ≥1.
- `SCORE_W`, default 3: width of each score counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin or restart a match.
- `player_valid`  in  1  player throw strobe.
- `player`  in  2  player throw: 00 scissors, 01 rock, 10 paper, 11 invalid.
- `computer`  in  2  current choice-counter value, same encoding.
- `counter_run`  out  1  1 = choice counter advances; 0 = frozen. Drives the counter's stop input.
- `result`  out  2  last round outcome: 00 player wins, 01 computer wins, 11 draw.
- `result_valid`  out  1  one-cycle pulse when `result` and the scores update.
- `player_score`  out  SCORE_W  player round wins this match.
- `cpu_score`  out  SCORE_W  computer round wins this match.
- `round_count`  out  8  rounds judged this match, including draws; wraps 255→0.
- `match_over`  out  1  high while in DONE.
- `match_winner`  out  1  0 player, 1 computer; valid while `match_over`=1.

## Operation
- FSM states: IDLE, SPIN, EVAL, REVEAL, DONE. Outputs are registered or Moore-decoded from state; there are no combinational input-to-output paths.
- **IDLE**
  - `counter_run`=0.
  - `start`=1 → SPIN and clear both scores, `round_count`, `result_valid` and `match_over`.
- **SPIN**
  - `counter_run`=1.
  - `player_valid`=1 and `player`≠11 → latch `player` and `computer` on the same edge, then go to EVAL.
  - `player`=11 with `player_valid`=1 is ignored; the FSM stays in SPIN.
- **EVAL** (1 cycle)
  - `counter_run`=0.
  - Judge the latched pair. Equal throws → 11. Player wins with scissors beating paper, rock beating scissors, and paper beating rock → 00. Any other pair → 01.
  - On exit, register `result` and increment the winner's score (a draw increments neither). Increment `round_count` and pulse `result_valid`.
  - Go to REVEAL.
- **REVEAL**
  - `counter_run`=0.
  - Hold for exactly REVEAL_CYCLES cycles.
  - After the last cycle: if `player_score`=WIN_TARGET → DONE with `match_winner`=0; if `cpu_score`=WIN_TARGET → DONE with `match_winner`=1; otherwise → SPIN.
- **DONE**
  - `counter_run`=0, `match_over`=1.
  - Scores, `result` and `round_count` are held.
  - `start` → SPIN with the same clearing as from IDLE.
- Ignored inputs:
  - `start` in SPIN, EVAL or REVEAL.
  - `player_valid` outside SPIN.
- Scores cannot exceed WIN_TARGET because the match ends on reaching it. No saturation logic is required.

## Timing
- Reset values: state IDLE, `counter_run` 0, `result` 11, `result_valid` 0, both scores 0, `round_count` 0, `match_over` 0, `match_winner` 0.
- `clear` dominates every other input on the same edge, including when asserted mid-round or in DONE.
- `start` sampled at edge k → `counter_run`=1 during cycle k+1.
- `player_valid` accepted at edge j:
  - `counter_run`=0 from cycle j+1.
  - `result_valid`=1 during cycle j+2 only, with the new `result`, scores and `round_count` visible in that cycle.
- The computer choice is the `computer` value sampled at edge j. Later counter movement has no effect.
- REVEAL occupies cycles j+2 … j+1+REVEAL_CYCLES. SPIN or DONE begins at cycle j+2+REVEAL_CYCLES.
- Minimum round period: REVEAL_CYCLES+2 cycles.

## Test plan
- Reset then idle: assert `clear` 2 cycles, hold `start`=0 → all outputs at their reset values, `counter_run`=0 indefinitely.
- Single round, player wins: `start`; then `player`=01 with `computer`=00 at accept edge j → `result`=00, `result_valid` pulse at j+2, `player_score`=1, `round_count`=1; SPIN resumes at j+6 (default parameters).
- Draw and invalid throw: in SPIN, `player_valid` with `player`=11 → no transition, `counter_run` stays 1. Then `player`=10 with `computer`=10 → `result`=11, both scores 0, `round_count`=1.
- Full match to DONE: three computer wins (01 vs 10 each round) → `cpu_score`=3, `match_over`=1, `match_winner`=1. Later `player_valid` pulses are ignored; `start` → scores 0, SPIN.
- Reset mid-operation: `clear` during EVAL and again during REVEAL → next cycle IDLE with all reset values, no `result_valid` pulse.
- Ignored `start` and round wrap: with WIN_TARGET=7 and 256 draws, plus `start` pulses during REVEAL → `round_count` wraps 255→0 and `start` in REVEAL has no effect.
